// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that stall decode on RAW hazards.
// The same-cycle writeback is discounted because the register file writes before it is read.
module reg_scoreboard #(
    parameter int NREG    = 8,
    parameter int MAXPEND = 3,
    parameter int SELW    = $clog2(NREG),
    parameter int CNTW    = $clog2(MAXPEND + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_issue_valid,
    input  logic            i_issue_wr,
    input  logic [SELW-1:0] i_issue_reg,
    input  logic            i_rs_used,
    input  logic [SELW-1:0] i_rs_sel,
    input  logic            i_rt_used,
    input  logic [SELW-1:0] i_rt_sel,
    input  logic            i_wb_valid,
    input  logic [SELW-1:0] i_wb_reg,
    input  logic            i_flush,
    output logic            o_stall,
    output logic [NREG-1:0] o_busy,
    output logic [2:0]      o_inflight,
    output logic            o_err
);

    localparam int SUMW = $clog2(NREG * MAXPEND + 1);

    logic [CNTW-1:0] r_cnt [NREG];
    logic            r_err;

    logic            w_wb_hit_rs;
    logic            w_wb_hit_rt;
    logic            w_rs_hit;
    logic            w_rt_hit;
    logic            w_accept;
    logic [NREG-1:0] w_inc;
    logic [NREG-1:0] w_dec;
    logic [CNTW-1:0] w_cnt_nxt [NREG];
    logic            w_err_set;
    logic [SUMW-1:0] w_sum;

    assign w_wb_hit_rs = i_wb_valid && (i_wb_reg == i_rs_sel);
    assign w_wb_hit_rt = i_wb_valid && (i_wb_reg == i_rt_sel);
    assign w_rs_hit    = i_rs_used && (r_cnt[i_rs_sel] > CNTW'(w_wb_hit_rs));
    assign w_rt_hit    = i_rt_used && (r_cnt[i_rt_sel] > CNTW'(w_wb_hit_rt));
    assign o_stall     = (w_rs_hit || w_rt_hit) && !i_flush;
    assign w_accept    = i_issue_valid && !o_stall && !i_flush;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_err_set = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            w_inc[i]     = w_accept && i_issue_wr && (i_issue_reg == SELW'(i));
            w_dec[i]     = i_wb_valid && (i_wb_reg == SELW'(i));
            w_cnt_nxt[i] = r_cnt[i];
            case ({w_inc[i], w_dec[i]})
                2'b10: begin
                    if (r_cnt[i] == CNTW'(MAXPEND)) w_err_set = 1'b1;
                    else                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
                2'b01: begin
                    if (r_cnt[i] == '0) w_err_set = 1'b1;
                    else                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                end
                default: w_cnt_nxt[i] = r_cnt[i];
            endcase
        end
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
            r_err <= 1'b0;
        end else if (i_flush) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_err <= r_err | w_err_set;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NREG; i++) begin
            o_busy[i] = (r_cnt[i] != '0);
            w_sum     = w_sum + SUMW'(r_cnt[i]);
        end
    end

    assign o_inflight = (w_sum > SUMW'(7)) ? 3'd7 : w_sum[2:0];
    assign o_err      = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a vector table walked cycle by cycle plus
// hand-written sequences for error, flush and asynchronous reset corner cases.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_wr, rs_used, rt_used, wb_valid, flush;
    logic [2:0] issue_reg, rs_sel, rt_sel, wb_reg;
    logic       stall, err;
    logic [7:0] busy;
    logic [2:0] inflight;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       iv, iw;
        logic [2:0] ireg;
        logic       rsu;
        logic [2:0] rss;
        logic       rtu;
        logic [2:0] rts;
        logic       wbv;
        logic [2:0] wbr;
        logic       fl;
        logic       e_stall;
        logic [7:0] e_busy;
        logic [2:0] e_infl;
        logic       e_err;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    reg_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .i_issue_valid (issue_valid),
        .i_issue_wr    (issue_wr),
        .i_issue_reg   (issue_reg),
        .i_rs_used     (rs_used),
        .i_rs_sel      (rs_sel),
        .i_rt_used     (rt_used),
        .i_rt_sel      (rt_sel),
        .i_wb_valid    (wb_valid),
        .i_wb_reg      (wb_reg),
        .i_flush       (flush),
        .o_stall       (stall),
        .o_busy        (busy),
        .o_inflight    (inflight),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_wr = 1'b0; issue_reg = 3'd0;
        rs_used = 1'b0; rs_sel = 3'd0; rt_used = 1'b0; rt_sel = 3'd0;
        wb_valid = 1'b0; wb_reg = 3'd0; flush = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        issue_valid = v.iv; issue_wr = v.iw; issue_reg = v.ireg;
        rs_used = v.rsu; rs_sel = v.rss; rt_used = v.rtu; rt_sel = v.rts;
        wb_valid = v.wbv; wb_reg = v.wbr; flush = v.fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue_cycle(input logic [2:0] r);
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_reg = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                iv  iw  ireg  rsu rss   rtu rts   wbv wbr   fl  | st  busy   infl  err
        vecs[0]  = '{1'b1,1'b1,3'd3, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h08,3'd1,1'b0};
        vecs[1]  = '{1'b1,1'b1,3'd4, 1'b1,3'd3, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b1,8'h08,3'd1,1'b0};
        vecs[2]  = '{1'b1,1'b1,3'd4, 1'b1,3'd3, 1'b0,3'd0, 1'b1,3'd3, 1'b0, 1'b0,8'h10,3'd1,1'b0};
        vecs[3]  = '{1'b0,1'b0,3'd0, 1'b0,3'd0, 1'b1,3'd4, 1'b0,3'd0, 1'b0, 1'b1,8'h10,3'd1,1'b0};
        vecs[4]  = '{1'b1,1'b0,3'd0, 1'b0,3'd0, 1'b1,3'd4, 1'b1,3'd4, 1'b0, 1'b0,8'h00,3'd0,1'b0};
        vecs[5]  = '{1'b1,1'b1,3'd5, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h20,3'd1,1'b0};
        vecs[6]  = '{1'b1,1'b1,3'd5, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h20,3'd2,1'b0};
        vecs[7]  = '{1'b1,1'b1,3'd5, 1'b0,3'd0, 1'b0,3'd0, 1'b1,3'd5, 1'b0, 1'b0,8'h20,3'd2,1'b0};
        vecs[8]  = '{1'b1,1'b1,3'd5, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h20,3'd3,1'b0};
        vecs[9]  = '{1'b1,1'b1,3'd5, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h20,3'd3,1'b1};
        vecs[10] = '{1'b1,1'b1,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h21,3'd4,1'b1};
        vecs[11] = '{1'b1,1'b1,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h21,3'd5,1'b1};
        vecs[12] = '{1'b1,1'b1,3'd1, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h23,3'd6,1'b1};
        vecs[13] = '{1'b1,1'b1,3'd1, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h23,3'd7,1'b1};
        vecs[14] = '{1'b1,1'b1,3'd1, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h23,3'd7,1'b1};
        vecs[15] = '{1'b1,1'b1,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h23,3'd7,1'b1};
        vecs[16] = '{1'b1,1'b1,3'd2, 1'b1,3'd5, 1'b0,3'd0, 1'b0,3'd0, 1'b1, 1'b0,8'h00,3'd0,1'b1};
        vecs[17] = '{1'b0,1'b1,3'd6, 1'b0,3'd0, 1'b0,3'd0, 1'b0,3'd0, 1'b0, 1'b0,8'h00,3'd0,1'b1};

        idle_inputs();
        rst = 1'b1;
        #2;
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_inflight", 32'(inflight), 32'h0);
        check("rst_err",      32'(err),      32'h0);
        check("rst_stall",    32'(stall),    32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_busy", i),     32'(busy),     32'(vecs[i].e_busy));
            check($sformatf("v%0d_inflight", i), 32'(inflight), 32'(vecs[i].e_infl));
            check($sformatf("v%0d_err", i),      32'(err),      32'(vecs[i].e_err));
        end

        // Writeback to an idle register flags an underflow and leaves it at zero.
        do_reset();
        check("uf_pre_err", 32'(err), 32'h0);
        wb_valid = 1'b1; wb_reg = 3'd2;
        @(posedge clk);
        #1;
        check("uf_err",      32'(err),      32'h1);
        check("uf_busy",     32'(busy),     32'h0);
        check("uf_inflight", 32'(inflight), 32'h0);

        // Flush beats a same-cycle issue and suppresses a would-be stall.
        do_reset();
        issue_cycle(3'd1);
        issue_cycle(3'd6);
        check("fl_pre_busy", 32'(busy), 32'h42);
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_reg = 3'd4;
        rt_used = 1'b1; rt_sel = 3'd6; flush = 1'b1;
        #1;
        check("fl_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        check("fl_busy",     32'(busy),     32'h0);
        check("fl_inflight", 32'(inflight), 32'h0);
        check("fl_err",      32'(err),      32'h0);

        // Reset asserted between edges clears state without waiting for the clock.
        issue_cycle(3'd7);
        check("ar_pre_busy", 32'(busy), 32'h80);
        @(negedge clk);
        idle_inputs();
        #1;
        rst = 1'b1;
        #1;
        check("ar_busy",     32'(busy),     32'h0);
        check("ar_inflight", 32'(inflight), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        issue_valid = 1'b1; issue_wr = 1'b1; issue_reg = 3'd7;
        @(posedge clk);
        #1;
        check("ar_post_busy",     32'(busy),     32'h80);
        check("ar_post_inflight", 32'(inflight), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
